bsg_nasti_req_arb: RTL

Round-robin arbiter that shares the single tunnel request port of the NASTI master request block among `num_req_p` requesters. Read address packets are granted one at a time. A write address packet locks the grant to its requester until that requester's write data beat marked `last` is accepted, so write bursts are never interleaved. The block tags each address packet's `id` with the requester index so responses can be routed back, and flags malformed burst lengths.

---
 rtl/bsg_nasti_pkg.sv | 41 ++++
 rtl/bsg_nasti_req_arb_rr_pick.sv | 32 +++
 rtl/bsg_nasti_req_arb.sv | 117 +++++++++++
 3 files changed

// File: rtl/bsg_nasti_pkg.sv
// Shared NASTI tunnel packet views and constants for the request path.
// One tunnel word is viewed either as an address packet or as a write-data beat.
package bsg_nasti_pkg;

  localparam int bsg_nasti_burst_len_gp = 8;
  localparam int bsg_nasti_id_width_gp  = 4;

  typedef logic [47:0] bsg_tun_dmx_t;

  // The top bit is rw in the address view and last in the write-data view.
  localparam int bsg_nasti_flag_bit_gp = $bits(bsg_tun_dmx_t) - 1;

  typedef struct packed {
    logic                             rw;
    logic [bsg_nasti_id_width_gp-1:0] id;
    logic [2:0]                       size;
    logic [7:0]                       len;
    logic [31:0]                      addr;
  } bsg_nasti_sa_pkt;

  typedef struct packed {
    logic        last;
    logic [6:0]  pad;
    logic [7:0]  strb;
    logic [31:0] data;
  } bsg_nasti_sw_pkt;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } bsg_nasti_arb_state_e;

  function automatic logic pkt_is_write(input bsg_tun_dmx_t p);
    return p[bsg_nasti_flag_bit_gp];
  endfunction

  function automatic logic pkt_is_last(input bsg_tun_dmx_t p);
    return p[bsg_nasti_flag_bit_gp];
  endfunction

endpackage

// File: rtl/bsg_nasti_req_arb_rr_pick.sv
// Combinational round-robin search: first valid requester at or after ptr_i, with wrap.
module bsg_nasti_rr_pick #(
  parameter int num_req_p = 2
) (
  input  logic [num_req_p-1:0]         valid_i,
  input  logic [$clog2(num_req_p)-1:0] ptr_i,
  output logic [$clog2(num_req_p)-1:0] winner_o,
  output logic                         v_o
);

  localparam int lg_lp = $clog2(num_req_p);

  logic [lg_lp:0]   sum;
  logic [lg_lp-1:0] idx;

  always_comb begin
    winner_o = ptr_i;
    v_o      = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int i = 0; i < num_req_p; i++) begin
      sum = {1'b0, ptr_i} + (lg_lp+1)'(i);
      if (sum >= (lg_lp+1)'(num_req_p)) sum = sum - (lg_lp+1)'(num_req_p);
      idx = sum[lg_lp-1:0];
      if (!v_o && valid_i[idx]) begin
        v_o      = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/bsg_nasti_req_arb.sv
// Round-robin arbiter onto the single NASTI tunnel request port; a write address
// locks the grant to its requester until that requester's last write beat.
module bsg_nasti_req_arb
  import bsg_nasti_pkg::*;
#(
  parameter int num_req_p   = 2,
  parameter int burst_len_p = bsg_nasti_burst_len_gp
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [num_req_p-1:0]         req_valid_i,
  input  bsg_tun_dmx_t                 req_data_i [num_req_p],
  output logic [num_req_p-1:0]         req_yumi_o,
  output logic                         arb_valid_o,
  output bsg_tun_dmx_t                 arb_data_o,
  input  logic                         arb_yumi_i,
  output logic [$clog2(num_req_p)-1:0] owner_o,
  output logic                         locked_o,
  output logic                         error_o
);

  localparam int lg_req_lp  = $clog2(num_req_p);
  localparam int lg_beat_lp = $clog2(burst_len_p);
  localparam logic [lg_req_lp-1:0]  last_req_lp  = lg_req_lp'(num_req_p - 1);
  localparam logic [lg_beat_lp-1:0] last_beat_lp = lg_beat_lp'(burst_len_p - 1);

  function automatic logic [lg_req_lp-1:0] next_ptr(input logic [lg_req_lp-1:0] p);
    return (p == last_req_lp) ? '0 : p + 1'b1;
  endfunction

  bsg_nasti_arb_state_e  state_r, state_n;
  logic [lg_req_lp-1:0]  rr_ptr_r, rr_ptr_n;
  logic [lg_req_lp-1:0]  owner_r, owner_n;
  logic [lg_beat_lp-1:0] beat_cnt_r, beat_cnt_n;
  logic                  error_r, error_n;

  logic [lg_req_lp-1:0]  pick_w, sel;
  logic                  pick_v, accept;
  bsg_nasti_sa_pkt       sa;

  bsg_nasti_rr_pick #(.num_req_p(num_req_p)) pick (
    .valid_i  (req_valid_i),
    .ptr_i    (rr_ptr_r),
    .winner_o (pick_w),
    .v_o      (pick_v)
  );

  assign sel = (state_r == ARB_LOCK) ? owner_r : pick_w;

  always_comb begin
    arb_valid_o = (state_r == ARB_LOCK) ? req_valid_i[owner_r] : pick_v;
    accept      = arb_valid_o & arb_yumi_i;
    req_yumi_o  = '0;
    req_yumi_o[sel] = accept;

    // Address packets carry the requester index in the low id bits for response routing.
    sa         = bsg_nasti_sa_pkt'(req_data_i[sel]);
    arb_data_o = req_data_i[sel];
    if (state_r == ARB_IDLE) begin
      sa.id[lg_req_lp-1:0] = pick_w;
      arb_data_o           = sa;
    end
  end

  always_comb begin
    state_n    = state_r;
    rr_ptr_n   = rr_ptr_r;
    owner_n    = owner_r;
    beat_cnt_n = beat_cnt_r;
    error_n    = error_r;
    unique case (state_r)
      ARB_IDLE: if (accept) begin
        owner_n = pick_w;
        if (pkt_is_write(req_data_i[pick_w])) begin
          state_n    = ARB_LOCK;
          beat_cnt_n = '0;
        end else begin
          rr_ptr_n = next_ptr(pick_w);
        end
      end
      ARB_LOCK: if (accept) begin
        if (pkt_is_last(req_data_i[owner_r])) begin
          if (beat_cnt_r != last_beat_lp) error_n = 1'b1;
          state_n  = ARB_IDLE;
          rr_ptr_n = next_ptr(owner_r);
        end else if (beat_cnt_r == last_beat_lp) begin
          // Counter saturates; only a last beat releases the lock.
          error_n = 1'b1;
        end else begin
          beat_cnt_n = beat_cnt_r + 1'b1;
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= ARB_IDLE;
      rr_ptr_r   <= '0;
      owner_r    <= '0;
      beat_cnt_r <= '0;
      error_r    <= 1'b0;
    end else begin
      state_r    <= state_n;
      rr_ptr_r   <= rr_ptr_n;
      owner_r    <= owner_n;
      beat_cnt_r <= beat_cnt_n;
      error_r    <= error_n;
    end
  end

  assign owner_o  = owner_r;
  assign locked_o = (state_r == ARB_LOCK);
  assign error_o  = error_r;

endmodule
